// File: rtl/rng_if.sv
// Carries the random value from the generator to its consumer.
// There is no handshake: the consumer samples rnd whenever it needs a value.
interface rng_if #(
    parameter int OUT_W = 12
) ();
    logic [OUT_W-1:0] rnd;

    modport master (output rnd);
    modport slave  (input  rnd);
endinterface

// File: rtl/rng.sv
// Free-running 16-bit maximal-length Galois LFSR (x^16+x^14+x^13+x^11+1).
// The low OUT_W bits of the state are presented as the random value.
module rng #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 12
) (
    input  logic   clk,
    input  logic   rst_n,
    rng_if.master  o_rng
);
    localparam logic [15:0] C_LOCKUP = 16'hACE1;
    localparam logic [15:0] C_TAPS   = 16'hB400;
    // A zero seed would stall the LFSR forever, so it is replaced by the default.
    localparam logic [15:0] C_SEED   = (SEED == 16'h0000) ? C_LOCKUP : SEED;

    // Declaration initialiser gives a defined power-up state even if rst_n never pulses.
    logic [15:0] r_state = C_SEED;
    logic [15:0] w_next;

    always_comb begin
        w_next = r_state >> 1;
        if (r_state == 16'h0000) begin
            w_next = C_LOCKUP;
        end else if (r_state[0]) begin
            w_next = (r_state >> 1) ^ C_TAPS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_SEED;
        end else begin
            r_state <= w_next;
        end
    end

    assign o_rng.rnd = r_state[OUT_W-1:0];
endmodule

// File: tb/tb_rng.sv
// Directed bench for the LFSR random generator: reset, sequence, async reset,
// no-reset startup, lockup recovery and full period.
module tb_rng;
    logic clk   = 1'b0;
    logic clk2  = 1'b0;
    logic rst_n = 1'b0;
    bit   clk_run = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [11:0] exp_q[$];
    logic [11:0] exp_nr_q[$];
    logic [15:0] m_state;

    rng_if #(.OUT_W(12)) u_if    ();
    rng_if #(.OUT_W(12)) u_if_nr ();
    rng_if #(.OUT_W(12)) u_if_z  ();

    rng #(.SEED(16'hACE1), .OUT_W(12)) u_dut (.clk(clk),  .rst_n(rst_n), .o_rng(u_if));
    rng #(.SEED(16'hACE1), .OUT_W(12)) u_nr  (.clk(clk2), .rst_n(1'b1),  .o_rng(u_if_nr));
    rng #(.SEED(16'h0000), .OUT_W(12)) u_z   (.clk(clk),  .rst_n(rst_n), .o_rng(u_if_z));

    // Main clock stays idle until clk_run is set.
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // No-reset instance: clock held low for 100 ns, then toggles every 5 ns.
    initial begin
        #100;
        forever #5 clk2 = ~clk2;
    end

    function automatic logic [15:0] model_next(input logic [15:0] s);
        if (s == 16'h0000) return 16'hACE1;
        if (s[0]) return (s >> 1) ^ 16'hB400;
        return s >> 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model, queue its prediction, then compare after the edge.
    task automatic edge_main(input string tag);
        logic [11:0] e;
        m_state = model_next(m_state);
        exp_q.push_back(m_state[11:0]);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, {20'h0, u_if.rnd}, {20'h0, e});
        check({tag, "_z"}, {20'h0, u_if_z.rnd}, {20'h0, e});
    endtask

    initial begin
        logic [11:0] seq6[6];
        logic [11:0] e;
        int period;
        int bad;

        seq6 = '{12'h270, 12'h138, 12'h89C, 12'hC4E, 12'hE27, 12'h313};

        // Reset value with no clock edges at all.
        #3;
        check("reset_val",      {20'h0, u_if.rnd},    32'hCE1);
        check("reset_val_seed0", {20'h0, u_if_z.rnd}, 32'hCE1);
        check("reset_state_seed0", {16'h0, u_z.r_state}, 32'hACE1);
        check("powerup_nr",     {20'h0, u_if_nr.rnd}, 32'hCE1);

        // No-reset startup: still CE1 before the first edge, then the known sequence.
        #47;
        check("powerup_nr_50ns", {20'h0, u_if_nr.rnd}, 32'hCE1);
        for (int i = 0; i < 6; i++) begin
            exp_nr_q.push_back(seq6[i]);
            @(posedge clk2);
            #1;
            e = exp_nr_q.pop_front();
            check($sformatf("nr_seq%0d", i), {20'h0, u_if_nr.rnd}, {20'h0, e});
        end

        // Clock running with reset held: state must not move.
        clk_run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", {20'h0, u_if.rnd}, 32'hCE1);

        // Release and run 20 edges against the model.
        @(negedge clk);
        rst_n   = 1'b1;
        m_state = 16'hACE1;
        for (int i = 0; i < 20; i++) begin
            edge_main($sformatf("seq%0d", i));
        end

        // Async reset pulse between edges: immediate return to seed.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {20'h0, u_if.rnd}, 32'hCE1);
        #1;
        rst_n   = 1'b1;
        m_state = 16'hACE1;
        edge_main("after_reset");
        check("after_reset_270", {20'h0, u_if.rnd}, 32'h270);

        // Lockup guard: an all-zero state recovers to ACE1 on the next edge.
        @(negedge clk);
        u_z.r_state = 16'h0000;
        #1;
        check("lockup_deposit", {20'h0, u_if_z.rnd}, 32'h0);
        @(posedge clk);
        #1;
        check("lockup_state", {16'h0, u_z.r_state}, 32'hACE1);
        check("lockup_rand",  {20'h0, u_if_z.rnd},  32'hCE1);

        // Full period from reset, bounded.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n   = 1'b1;
        m_state = 16'hACE1;
        period  = 0;
        bad     = 0;
        while (period < 70000) begin
            @(posedge clk);
            #1;
            period++;
            m_state = model_next(m_state);
            if (u_if.rnd !== m_state[11:0]) bad++;
            if ($isunknown(u_if.rnd) || u_dut.r_state == 16'h0000) bad++;
            if (u_dut.r_state == 16'hACE1) break;
        end
        check("period", period, 32'd65535);
        check("period_bad_samples", bad, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
